// File: rtl/cond_parser_pkg.sv
// Shared state/operator types, error codes and ASCII constants for the
// conditional-assignment parser.
package cond_parser_pkg;

  typedef enum logic [4:0] {
    S_IDLE, S_KW_IF, S_LPAREN, S_VAR, S_VARIDX, S_CMP1, S_CMP2, S_NUM_C,
    S_RPAREN, S_KW_BEGIN, S_P_ID, S_LT, S_EQ, S_NUM_A, S_SEMI, S_KW_END,
    S_ELSE_OR_DONE, S_KW_ELSE, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [2:0] {OP_EQ, OP_NE, OP_LT, OP_GT, OP_LE, OP_GE} cmp_op_t;

  typedef enum logic [1:0] {KW_BEGIN, KW_END, KW_ELSE} kw_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CHAR  = 3'd1;
  localparam logic [2:0] ERR_OVF   = 3'd2;
  localparam logic [2:0] ERR_VAR   = 3'd3;
  localparam logic [2:0] ERR_TRUNC = 3'd4;
  localparam logic [2:0] ERR_TRAIL = 3'd5;

  localparam logic [6:0] CH_SP   = 7'h20;
  localparam logic [6:0] CH_TAB  = 7'h09;
  localparam logic [6:0] CH_LF   = 7'h0A;
  localparam logic [6:0] CH_CR   = 7'h0D;
  localparam logic [6:0] CH_0    = 7'h30;
  localparam logic [6:0] CH_9    = 7'h39;
  localparam logic [6:0] CH_LPAR = 7'h28;
  localparam logic [6:0] CH_RPAR = 7'h29;
  localparam logic [6:0] CH_BANG = 7'h21;
  localparam logic [6:0] CH_LT   = 7'h3C;
  localparam logic [6:0] CH_EQ   = 7'h3D;
  localparam logic [6:0] CH_GT   = 7'h3E;
  localparam logic [6:0] CH_SEMI = 7'h3B;
  localparam logic [6:0] CH_B    = 7'h62;
  localparam logic [6:0] CH_D    = 7'h64;
  localparam logic [6:0] CH_E    = 7'h65;
  localparam logic [6:0] CH_F    = 7'h66;
  localparam logic [6:0] CH_G    = 7'h67;
  localparam logic [6:0] CH_I    = 7'h69;
  localparam logic [6:0] CH_L    = 7'h6C;
  localparam logic [6:0] CH_N    = 7'h6E;
  localparam logic [6:0] CH_P    = 7'h70;
  localparam logic [6:0] CH_S    = 7'h73;
  localparam logic [6:0] CH_X    = 7'h78;

  function automatic logic is_ws(input logic [6:0] c);
    return (c == CH_SP) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
  endfunction

  function automatic logic is_digit(input logic [6:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  // Expected character at position pos of a multi-letter keyword.
  function automatic logic [6:0] kw_char(input kw_t kw, input logic [2:0] pos);
    logic [6:0] c;
    c = 7'h00;
    case (kw)
      KW_BEGIN:
        case (pos)
          3'd0: c = CH_B;
          3'd1: c = CH_E;
          3'd2: c = CH_G;
          3'd3: c = CH_I;
          3'd4: c = CH_N;
          default: c = 7'h00;
        endcase
      KW_END:
        case (pos)
          3'd0: c = CH_E;
          3'd1: c = CH_N;
          3'd2: c = CH_D;
          default: c = 7'h00;
        endcase
      KW_ELSE:
        case (pos)
          3'd0: c = CH_E;
          3'd1: c = CH_L;
          3'd2: c = CH_S;
          3'd3: c = CH_E;
          default: c = 7'h00;
        endcase
      default: c = 7'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cond_assign_parser_dec_accum.sv
// Decimal accumulator: acc = acc*10 + digit, with a look-ahead flag that the
// incoming digit would push the value past DATA_W bits.
module dec_accum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] value,
  output logic              ovf
);

  localparam int AW = DATA_W + 4;

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;

  // acc never exceeds 2^DATA_W-1 while parsing continues, so *10+9 fits AW bits.
  assign acc_next = (acc * AW'(10)) + AW'(digit);
  assign ovf      = |acc_next[AW-1:DATA_W];
  assign value    = acc[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/cond_assign_parser.sv
// Streaming ASCII parser/executor for
// if(x<k> CMP NUM)begin p<=NUM;end[else begin p<=NUM;end]
module cond_assign_parser
  import cond_parser_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_X      = 4,
  parameter int SIGNED_CMP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_X*DATA_W-1:0] x,
  input  logic [6:0]              ascii_char,
  input  logic                    char_valid,
  input  logic                    char_last,
  output logic                    char_ready,
  input  logic                    clear,
  output logic [DATA_W-1:0]       p,
  output logic                    p_updated,
  output logic                    parsing_done,
  output logic                    error_flag,
  output logic [2:0]              err_code
);

  // state          | meaning
  // IDLE..VARIDX   | "if", "(", "x", single index digit
  // CMP1/CMP2      | first/second operator char; CMP2 may hand a digit to NUM_C
  // NUM_C/RPAREN   | condition constant, then ")" (condition latched here)
  // KW_BEGIN..SEMI | "begin", "p", "<", "=", constant, ";" (write if branch taken)
  // KW_END         | "end"; its final 'd' is a terminal point
  // ELSE_OR_DONE   | after end: whitespace, "else" (then branch only), or finish
  // KW_ELSE        | rest of "else", then the else copy of KW_BEGIN..KW_END
  // DONE/ERROR     | parked until clear or rst

  state_t      state, state_nxt;
  cmp_op_t     op, op_nxt;
  logic [2:0]  kw_pos, kw_pos_nxt;
  logic [3:0]  var_idx, var_idx_nxt;
  logic        num_seen, num_seen_nxt;
  logic        in_else, in_else_nxt;
  logic        cond_t, cond_nxt;
  logic [2:0]  err_nxt;
  logic        acc_clr, acc_en, acc_ovf, p_wr, term;
  logic [DATA_W-1:0] num_val;
  logic [DATA_W-1:0] x_sel;
  logic signed [DATA_W:0] lhs, rhs;
  logic        cmp_res;
  kw_t         kw_sel;
  logic        accept, ws, dig, kw_hit;
  logic [3:0]  dval;
  logic [6:0]  ch;

  assign char_ready   = !clear && (state != S_DONE) && (state != S_ERROR);
  assign accept       = char_valid && char_ready;
  assign parsing_done = (state == S_DONE);
  assign error_flag   = (state == S_ERROR);

  assign ch   = ascii_char;
  assign ws   = is_ws(ch);
  assign dig  = is_digit(ch);
  assign dval = ch[3:0];

  always_comb begin
    kw_sel = KW_BEGIN;
    if (state == S_KW_END)       kw_sel = KW_END;
    else if (state == S_KW_ELSE) kw_sel = KW_ELSE;
  end
  assign kw_hit = (ch == kw_char(kw_sel, kw_pos));

  dec_accum #(.DATA_W(DATA_W)) u_accum (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr || clear),
    .en    (acc_en),
    .digit (dval),
    .value (num_val),
    .ovf   (acc_ovf)
  );

  // Constants are non-negative, so one extra bit lets a single signed compare
  // cover both the signed and unsigned interpretation of x.
  assign x_sel = x[int'(var_idx)*DATA_W +: DATA_W];
  assign lhs   = (SIGNED_CMP != 0) ? {x_sel[DATA_W-1], x_sel} : {1'b0, x_sel};
  assign rhs   = {1'b0, num_val};

  always_comb begin
    cmp_res = 1'b0;
    case (op)
      OP_EQ:   cmp_res = (lhs == rhs);
      OP_NE:   cmp_res = (lhs != rhs);
      OP_LT:   cmp_res = (lhs <  rhs);
      OP_GT:   cmp_res = (lhs >  rhs);
      OP_LE:   cmp_res = (lhs <= rhs);
      OP_GE:   cmp_res = (lhs >= rhs);
      default: cmp_res = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    op_nxt       = op;
    kw_pos_nxt   = kw_pos;
    var_idx_nxt  = var_idx;
    num_seen_nxt = num_seen;
    in_else_nxt  = in_else;
    cond_nxt     = cond_t;
    err_nxt      = ERR_NONE;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    p_wr         = 1'b0;
    term         = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE:
          if (ch == CH_I) begin
            state_nxt   = S_KW_IF;
            in_else_nxt = 1'b0;
          end else if (!ws) err_nxt = ERR_CHAR;
        S_KW_IF:
          if (ch == CH_F) state_nxt = S_LPAREN;
          else            err_nxt   = ERR_CHAR;
        S_LPAREN:
          if (ch == CH_LPAR) state_nxt = S_VAR;
          else if (!ws)      err_nxt   = ERR_CHAR;
        S_VAR:
          if (ch == CH_X) state_nxt = S_VARIDX;
          else if (!ws)   err_nxt   = ERR_CHAR;
        S_VARIDX:
          if (!dig)                      err_nxt = ERR_CHAR;
          else if (int'(dval) >= NUM_X)  err_nxt = ERR_VAR;
          else begin
            var_idx_nxt = dval;
            state_nxt   = S_CMP1;
          end
        S_CMP1: begin
          acc_clr      = 1'b1;
          num_seen_nxt = 1'b0;
          state_nxt    = S_CMP2;
          case (ch)
            CH_EQ:   op_nxt = OP_EQ;
            CH_BANG: op_nxt = OP_NE;
            CH_LT:   op_nxt = OP_LT;
            CH_GT:   op_nxt = OP_GT;
            default: begin
              state_nxt = S_CMP1;
              if (!ws) err_nxt = ERR_CHAR;
            end
          endcase
        end
        S_CMP2:
          if (ch == CH_EQ) begin
            state_nxt = S_NUM_C;
            if (op == OP_LT)      op_nxt = OP_LE;
            else if (op == OP_GT) op_nxt = OP_GE;
          end else if (op == OP_EQ || op == OP_NE) begin
            err_nxt = ERR_CHAR;
          end else if (ws) begin
            state_nxt = S_NUM_C;
          end else if (dig) begin
            state_nxt    = S_NUM_C;
            acc_en       = 1'b1;
            num_seen_nxt = 1'b1;
          end else err_nxt = ERR_CHAR;
        S_NUM_C, S_RPAREN:
          if (state == S_NUM_C && dig) begin
            acc_en       = 1'b1;
            num_seen_nxt = 1'b1;
            if (acc_ovf) err_nxt = ERR_OVF;
          end else if (state == S_NUM_C && !num_seen) begin
            if (!ws) err_nxt = ERR_CHAR;
          end else if (ch == CH_RPAR) begin
            cond_nxt   = cmp_res;
            state_nxt  = S_KW_BEGIN;
            kw_pos_nxt = 3'd0;
          end else if (ws) begin
            state_nxt = S_RPAREN;
          end else err_nxt = ERR_CHAR;
        S_KW_BEGIN:
          if (kw_pos == 3'd0 && ws) begin
            state_nxt = S_KW_BEGIN;
          end else if (!kw_hit) begin
            err_nxt = ERR_CHAR;
          end else if (kw_pos == 3'd4) begin
            state_nxt  = S_P_ID;
            kw_pos_nxt = 3'd0;
          end else kw_pos_nxt = kw_pos + 3'd1;
        S_P_ID:
          if (ch == CH_P) state_nxt = S_LT;
          else if (!ws)   err_nxt   = ERR_CHAR;
        S_LT:
          if (ch == CH_LT) state_nxt = S_EQ;
          else if (!ws)    err_nxt   = ERR_CHAR;
        S_EQ:
          if (ch == CH_EQ) begin
            state_nxt    = S_NUM_A;
            acc_clr      = 1'b1;
            num_seen_nxt = 1'b0;
          end else err_nxt = ERR_CHAR;
        S_NUM_A, S_SEMI:
          if (state == S_NUM_A && dig) begin
            acc_en       = 1'b1;
            num_seen_nxt = 1'b1;
            if (acc_ovf) err_nxt = ERR_OVF;
          end else if (state == S_NUM_A && !num_seen) begin
            if (!ws) err_nxt = ERR_CHAR;
          end else if (ch == CH_SEMI) begin
            p_wr       = in_else ? !cond_t : cond_t;
            state_nxt  = S_KW_END;
            kw_pos_nxt = 3'd0;
          end else if (ws) begin
            state_nxt = S_SEMI;
          end else err_nxt = ERR_CHAR;
        S_KW_END:
          if (kw_pos == 3'd0 && ws) begin
            state_nxt = S_KW_END;
          end else if (!kw_hit) begin
            err_nxt = ERR_CHAR;
          end else if (kw_pos == 3'd2) begin
            term       = 1'b1;
            state_nxt  = S_ELSE_OR_DONE;
            kw_pos_nxt = 3'd0;
          end else kw_pos_nxt = kw_pos + 3'd1;
        S_ELSE_OR_DONE:
          if (ws) begin
            term = 1'b1;
          end else if (in_else) begin
            err_nxt = ERR_TRAIL;
          end else if (ch == CH_E) begin
            state_nxt  = S_KW_ELSE;
            kw_pos_nxt = 3'd1;
          end else err_nxt = ERR_CHAR;
        S_KW_ELSE:
          if (!kw_hit) begin
            err_nxt = ERR_CHAR;
          end else if (kw_pos == 3'd3) begin
            state_nxt   = S_KW_BEGIN;
            kw_pos_nxt  = 3'd0;
            in_else_nxt = 1'b1;
          end else kw_pos_nxt = kw_pos + 3'd1;
        default: state_nxt = state;
      endcase
      // A character's own error outranks a misplaced char_last.
      if (err_nxt == ERR_NONE && char_last && !term) err_nxt = ERR_TRUNC;
      if (err_nxt != ERR_NONE) begin
        state_nxt = S_ERROR;
        p_wr      = 1'b0;
      end else if (char_last) begin
        state_nxt = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op        <= OP_EQ;
      kw_pos    <= 3'd0;
      var_idx   <= 4'd0;
      num_seen  <= 1'b0;
      in_else   <= 1'b0;
      cond_t    <= 1'b0;
      err_code  <= ERR_NONE;
      p         <= '0;
      p_updated <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      kw_pos    <= 3'd0;
      num_seen  <= 1'b0;
      in_else   <= 1'b0;
      err_code  <= ERR_NONE;
      p_updated <= 1'b0;
    end else begin
      p_updated <= p_wr;
      if (p_wr) p <= num_val;
      if (accept) begin
        state    <= state_nxt;
        op       <= op_nxt;
        kw_pos   <= kw_pos_nxt;
        var_idx  <= var_idx_nxt;
        num_seen <= num_seen_nxt;
        in_else  <= in_else_nxt;
        cond_t   <= cond_nxt;
        if (err_nxt != ERR_NONE) err_code <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cond_assign_parser.sv
// Directed bench: a vector table on the default instance, plus hand sequences
// for signed compare, narrow width, clear, gaps and mid-parse reset.
module tb_cond_assign_parser;

  localparam int W = 32;

  logic clk, rst, clear, char_valid, char_last;
  logic [6:0] ascii_char;
  logic [4*W-1:0] x;
  logic [31:0] x8;

  logic [W-1:0] p_a, p_s;
  logic [7:0]   p_8;
  logic upd_a, upd_s, upd_8, done_a, done_s, done_8;
  logic eflag_a, eflag_s, eflag_8, rdy_a, rdy_s, rdy_8;
  logic [2:0] code_a, code_s, code_8;

  int errors = 0;
  int checks = 0;
  int upd_cnt = 0;

  typedef struct {
    string       txt;
    logic [31:0] xv;
    int          last;   // -1: char_last on final character
    logic [31:0] ep;
    logic        edone;
    logic [2:0]  ecode;
    int          eupd;
  } vec_t;

  vec_t vecs[$];

  cond_assign_parser #(.DATA_W(32), .NUM_X(4), .SIGNED_CMP(0)) dut (
    .clk(clk), .rst(rst), .x(x), .ascii_char(ascii_char), .char_valid(char_valid),
    .char_last(char_last), .char_ready(rdy_a), .clear(clear), .p(p_a), .p_updated(upd_a),
    .parsing_done(done_a), .error_flag(eflag_a), .err_code(code_a));

  cond_assign_parser #(.DATA_W(32), .NUM_X(4), .SIGNED_CMP(1)) dut_s (
    .clk(clk), .rst(rst), .x(x), .ascii_char(ascii_char), .char_valid(char_valid),
    .char_last(char_last), .char_ready(rdy_s), .clear(clear), .p(p_s), .p_updated(upd_s),
    .parsing_done(done_s), .error_flag(eflag_s), .err_code(code_s));

  cond_assign_parser #(.DATA_W(8), .NUM_X(4), .SIGNED_CMP(0)) dut_8 (
    .clk(clk), .rst(rst), .x(x8), .ascii_char(ascii_char), .char_valid(char_valid),
    .char_last(char_last), .char_ready(rdy_8), .clear(clear), .p(p_8), .p_updated(upd_8),
    .parsing_done(done_8), .error_flag(eflag_8), .err_code(code_8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (upd_a) upd_cnt++;
  endtask

  task automatic send(input string s, input int last_at, input int gap);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      ascii_char = b[6:0];
      char_valid = 1'b1;
      char_last  = (i == last_at);
      tick();
      for (int g = 0; g < gap; g++) begin
        char_valid = 1'b0;
        char_last  = 1'b0;
        tick();
      end
    end
    char_valid = 1'b0;
    char_last  = 1'b0;
    ascii_char = 7'h00;
    repeat (3) tick();
  endtask

  task automatic send_all(input string s);
    send(s, s.len() - 1, 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic set_x(input logic [31:0] v);
    x  = {4{v}};
    x8 = {4{v[7:0]}};
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; char_valid = 1'b0; char_last = 1'b0;
    ascii_char = 7'h00; x = '0; x8 = '0;

    vecs.push_back('{"if(x0>5)begin p<=20;end else begin p<=30;end", 32'd6, -1, 32'd20, 1'b1, 3'd0, 1});
    vecs.push_back('{"if(x2<=3)begin p<=20;end else begin p<=30;end", 32'd4, -1, 32'd30, 1'b1, 3'd0, 1});
    vecs.push_back('{"if ( x3 != 7 ) begin p <= 1234 ; end", 32'd7, -1, 32'd30, 1'b1, 3'd0, 0});
    vecs.push_back('{"if(x1>=100)begin p<=4294967295;end", 32'd100, -1, 32'hFFFF_FFFF, 1'b1, 3'd0, 1});
    vecs.push_back('{"if(x0==0)begin p<=4294967296;end", 32'd0, -1, 32'hFFFF_FFFF, 1'b0, 3'd2, 0});
    vecs.push_back('{"if(x7<1)begin p<=1;end", 32'd0, -1, 32'hFFFF_FFFF, 1'b0, 3'd3, 0});
    vecs.push_back('{"ifx", 32'd0, -1, 32'hFFFF_FFFF, 1'b0, 3'd1, 0});
    vecs.push_back('{"if(x0)begin p<=1;end", 32'd0, -1, 32'hFFFF_FFFF, 1'b0, 3'd1, 0});
    vecs.push_back('{"if(x0<5)begin p<=1;end", 32'd0, 7, 32'hFFFF_FFFF, 1'b0, 3'd4, 0});
    vecs.push_back('{"if(x0==0)begin p<=6;end", 32'd0, 19, 32'hFFFF_FFFF, 1'b0, 3'd4, 0});
    vecs.push_back('{"if(x0<5)begin p<=2;end else begin p<=3;end ;", 32'd1, -1, 32'd2, 1'b0, 3'd5, 1});
    vecs.push_back('{"if(x0>9)begin p<=5;end   ", 32'd10, -1, 32'd5, 1'b1, 3'd0, 1});
    vecs.push_back('{"if(x0 <3)begin p<=8;end else begin p<=9;end", 32'd3, -1, 32'd9, 1'b1, 3'd0, 1});
    vecs.push_back('{"if(x0< )begin p<=1;end", 32'd0, -1, 32'd9, 1'b0, 3'd1, 0});
    vecs.push_back('{"if(x0<1)beg in p<=1;end", 32'd0, -1, 32'd9, 1'b0, 3'd1, 0});
    vecs.push_back('{"if(x3>=0)begin p<=0;end", 32'd0, -1, 32'd0, 1'b1, 3'd0, 1});

    repeat (2) @(negedge clk);
    chk("reset_a", {p_a, upd_a, done_a, eflag_a, code_a, rdy_a}, {32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    chk("reset_s", {p_s, upd_s, done_s, eflag_s, code_s, rdy_s}, {32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    chk("reset_8", {p_8, upd_8, done_8, eflag_8, code_8, rdy_8}, {8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      set_x(vecs[i].xv);
      pulse_clear();
      upd_cnt = 0;
      send(vecs[i].txt, (vecs[i].last < 0) ? vecs[i].txt.len() - 1 : vecs[i].last, 0);
      chk($sformatf("v%0d_p", i), p_a, vecs[i].ep);
      chk($sformatf("v%0d_done", i), done_a, vecs[i].edone);
      chk($sformatf("v%0d_errflag", i), eflag_a, (vecs[i].ecode != 3'd0));
      chk($sformatf("v%0d_errcode", i), code_a, vecs[i].ecode);
      chk($sformatf("v%0d_updates", i), upd_cnt, vecs[i].eupd);
    end

    // signed vs unsigned compare of x1 = -1 against 0
    set_x(32'd0);
    pulse_clear();
    send_all("if(x0==0)begin p<=99;end");
    chk("seed_p_a", p_a, 32'd99);
    chk("seed_p_s", p_s, 32'd99);
    chk("seed_p_8", p_8, 8'd99);
    set_x(32'hFFFF_FFFF);
    pulse_clear();
    upd_cnt = 0;
    send_all("if(x1<0)begin p<=7;end");
    chk("unsigned_neg_p", p_a, 32'd99);
    chk("unsigned_neg_done", done_a, 1'b1);
    chk("unsigned_neg_upd", upd_cnt, 0);
    chk("signed_neg_p", p_s, 32'd7);
    chk("signed_neg_done", done_s, 1'b1);

    // 256 overflows an 8-bit constant but is legal at 32 bits
    set_x(32'd0);
    pulse_clear();
    send_all("if(x0==0)begin p<=256;end");
    chk("w8_ovf_code", code_8, 3'd2);
    chk("w8_ovf_flag", eflag_8, 1'b1);
    chk("w8_ovf_p", p_8, 8'd99);
    chk("w32_256_p", p_a, 32'd256);

    // truncated stream, then clear with a char offered in the same cycle
    pulse_clear();
    send("if(x0<5)begin p<=1;end", 7, 0);
    chk("trunc_code", code_a, 3'd4);
    ascii_char = 7'h69;
    char_valid = 1'b1;
    clear = 1'b1;
    #1;
    chk("clear_ready_low", rdy_a, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    char_valid = 1'b0;
    chk("clear_errflag", eflag_a, 1'b0);
    chk("clear_code", code_a, 3'd0);
    chk("clear_p_kept", p_a, 32'd256);
    send_all("if(x0<5)begin p<=41;end");
    chk("after_clear_p", p_a, 32'd41);
    chk("after_clear_done", done_a, 1'b1);

    // gaps between characters, then reset in the middle of "begin"
    set_x(32'd6);
    pulse_clear();
    upd_cnt = 0;
    send("if(x0>5)begin p<=77;end", 22, 2);
    chk("gap_p", p_a, 32'd77);
    chk("gap_done", done_a, 1'b1);
    chk("gap_updates", upd_cnt, 1);
    pulse_clear();
    send("if(x0>5)beg", 1000, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", {p_a, upd_a, done_a, eflag_a, code_a, rdy_a}, {32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    rst = 1'b0;
    @(negedge clk);
    send_all("if(x0>5)begin p<=55;end");
    chk("midrst_p", p_a, 32'd55);
    chk("midrst_done", done_a, 1'b1);
    chk("midrst_code", code_a, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
